multiplier_unit_iterative: RTL
==============================

// Module: multiplier_unit_iterative
// PURPOSE
//  Parametrised, multi-cycle RV M-extension multiplier (MUL/MULH/MULHSU/MULHU) for the execute stage.
//  Consumes STEP_BITS multiplier bits per cycle, raising mul_unit_busy to stall the pipeline.
//  Optional approximate mode truncates operand LSBs under accuracy_level control.
//  A MULH*-after-MUL fusion cache returns the other product half in one cycle.
// PARAMETERS
//  XLEN        32  operand/result width; even, >= 8
//  STEP_BITS   2   multiplier bits retired per CALC cycle; 1, 2 or 4; must divide XLEN
//  APPROXIMATE 0   1 enables accuracy_level operand truncation; 0 ignores accuracy_level
// PORTS
//  CLK            in   1     clock, rising edge
//  reset          in   1     asynchronous, active-low reset
//  start          in   1     request strobe; qualified by decode below
//  opcode         in   7     must be 7'b0110011
//  funct7         in   7     must be 7'b0000001
//  funct3         in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx = not ours
//  accuracy_level in   8     approximate truncation depth (APPROXIMATE=1 only)
//  rs1            in   XLEN  multiplicand
//  rs2            in   XLEN  multiplier
//  mul_unit_busy  out  1     high while an operation is in CALC
//  mul_valid      out  1     one-cycle pulse: mul_output holds a new result
//  mul_output     out  XLEN  result; held until next result
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; mul_unit_busy=0, mul_valid=0, mul_output=0; fusion cache invalid.
//  Accept: start & decode match & state!=CALC, sampled at rising edge; accepted in IDLE or DONE (back-to-back).
//   No decode match, or start in CALC: ignored, no state change.
//  Operand prep: sign per funct3 (MUL/MULH s*s, MULHSU s*u, MULHU u*u); magnitudes |rs1|,|rs2| latched.
//   APPROXIMATE=1: low min(accuracy_level, XLEN/2) bits of both magnitudes zeroed; level 0 = exact.
//  FSM:
//   IDLE -> CALC on accept (non-fused); counter = XLEN/STEP_BITS.
//   CALC: per cycle, add magnitude*step-digit to 2*XLEN accumulator, shift, counter--; busy=1.
//   CALC -> DONE when counter reaches 0 after the last step.
//   DONE: 1 cycle; apply sign (two's-complement negate of 2*XLEN product if signs differ);
//         mul_output = low XLEN (MUL) or high XLEN (MULH*); mul_valid=1; busy=0. -> IDLE, or CALC on accept.
//  Latency: accept at edge t -> mul_valid high in cycle after edge t+XLEN/STEP_BITS+1 (17 for defaults).
//   Busy is registered: it first reads 1 in the cycle after the accept edge.
//  Fusion: cache = {rs1, rs2, funct3 signedness, accuracy_level, full 2*XLEN signed product}, valid after DONE.
//   Accepted op with identical rs1/rs2/signedness/level, any funct3 selecting the other half
//   or the same half: skip CALC, go straight to DONE (mul_valid 1 cycle after accept); busy stays 0.
//   Any non-matching accept, or reset, invalidates cache until next DONE.
//  Widths: internal accumulator 2*XLEN+STEP_BITS bits; no overflow flags; MUL low half is sign-agnostic.
//  Edge values: most-negative*most-negative MULH = 2^(XLEN-2); x*0 = 0; -1*-1 MULHU = 2^XLEN-2 high half.
//  Reset mid-CALC: abort immediately; no mul_valid; mul_output returns to 0.
//  Inputs need only be stable at the accept edge; later changes have no effect.
// TESTING
//  1 MUL rs1=10 rs2=20 level=0 -> busy 16 cycles, mul_valid once, mul_output=200, 17-cycle latency.
//  2 MUL rs1=-3 rs2=7 -> 0xFFFFFFEB; then MULH same operands -> 0xFFFFFFFF in 1 cycle (fused, busy 0).
//  3 MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=-1 rs2=0xFFFFFFFF -> 0xFFFFFFFF.
//  4 APPROXIMATE=1, MUL rs1=0x1F rs2=0x13 level=4 -> 0x100 (0x10*0x10); level=0 -> 0x24D exact.
//  5 start of second MUL while busy -> ignored; first result only; funct3=100 in IDLE -> no busy, no valid.
//  6 reset low at CALC cycle 5 -> busy=0, mul_output=0 instantly, no mul_valid; next MUL 6*7 -> 42 full latency.

Source files
------------

// File: rtl/multiplier_unit_iterative_if.sv
// Request/response bundle for the iterative M-extension multiplier.
//   master side (issuing stage): start, opcode, funct7, funct3, accuracy_level, rs1, rs2
//   slave side (multiplier):     mul_unit_busy, mul_valid, mul_output
interface multiplier_unit_iterative_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [7:0]      accuracy_level;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            mul_unit_busy;
  logic            mul_valid;
  logic [XLEN-1:0] mul_output;

  modport master (
    output start, opcode, funct7, funct3, accuracy_level, rs1, rs2,
    input  mul_unit_busy, mul_valid, mul_output
  );

  modport slave (
    input  start, opcode, funct7, funct3, accuracy_level, rs1, rs2,
    output mul_unit_busy, mul_valid, mul_output
  );
endinterface

// File: rtl/multiplier_unit_iterative.sv
// Multi-cycle RV M-extension multiplier (MUL/MULH/MULHSU/MULHU).
// Retires STEP_BITS multiplier bits per CALC cycle on unsigned magnitudes,
// applies the sign in DONE. A one-entry cache of the last full product lets
// a repeat of the same operands (either half) complete without CALC.
// Optional operand LSB truncation when APPROXIMATE != 0.
// Ports:
//   CLK   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave modport: start/decode/operands in; busy, valid, result out
module multiplier_unit_iterative #(
  parameter int XLEN        = 32,
  parameter int STEP_BITS   = 2,
  parameter int APPROXIMATE = 0
) (
  input  logic                        CLK,
  input  logic                        reset,
  multiplier_unit_iterative_if.slave  bus
);
  localparam int          STEPS = XLEN / STEP_BITS;
  localparam int          CW    = $clog2(STEPS + 1);
  localparam int          AW    = 2 * XLEN + STEP_BITS;
  localparam int unsigned HALF  = XLEN / 2;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [6:0]  F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;

  // Operation registers
  logic [XLEN-1:0]   mcand, mplr;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic              neg, hi_half, fused;

  // Fusion cache
  logic              cache_valid;
  logic [XLEN-1:0]   c_rs1, c_rs2;
  logic [1:0]        c_cls;
  logic [7:0]        c_lvl;
  logic [2*XLEN-1:0] cache_prod;

  // Request decode / operand prep
  logic              sgn1, sgn2, neg1, neg2, accept, cache_hit;
  logic [1:0]        cls;
  logic [7:0]        lvl;
  int unsigned       trunc;
  logic [XLEN-1:0]   keep, mag1, mag2;

  // Step datapath
  logic [STEP_BITS-1:0]      digit;
  logic [XLEN+STEP_BITS-1:0] pp;
  logic [AW-1:0]             acc_sum;
  logic [2*XLEN-1:0]         prod, result;

  always_comb begin
    sgn1  = (bus.funct3[1:0] != 2'b11);
    sgn2  = !bus.funct3[1];
    cls   = {sgn1, sgn2};
    lvl   = (APPROXIMATE != 0) ? bus.accuracy_level : 8'd0;
    trunc = (32'(lvl) < HALF) ? 32'(lvl) : HALF;
    keep  = {XLEN{1'b1}} << trunc;
    neg1  = sgn1 & bus.rs1[XLEN-1];
    neg2  = sgn2 & bus.rs2[XLEN-1];
    mag1  = (neg1 ? ({XLEN{1'b0}} - bus.rs1) : bus.rs1) & keep;
    mag2  = (neg2 ? ({XLEN{1'b0}} - bus.rs2) : bus.rs2) & keep;
    accept = bus.start && (bus.opcode == OPC_OP) && (bus.funct7 == F7_MULDIV)
             && !bus.funct3[2] && (state != CALC);
    // In DONE the cache is about to hold the current op's product, so a
    // back-to-back repeat is treated as a hit against the current keys.
    cache_hit = (cache_valid || (state == DONE))
                && (bus.rs1 == c_rs1) && (bus.rs2 == c_rs2)
                && (cls == c_cls) && (lvl == c_lvl);
  end

  always_comb begin
    digit   = mplr[STEP_BITS-1:0];
    pp      = {{STEP_BITS{1'b0}}, mcand} * {{XLEN{1'b0}}, digit};
    acc_sum = acc + {pp, {XLEN{1'b0}}};
    prod    = neg ? ({(2*XLEN){1'b0}} - acc[2*XLEN-1:0]) : acc[2*XLEN-1:0];
    result  = fused ? cache_prod : prod;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = cache_hit ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_n = DONE;
      DONE:    if (accept) state_n = cache_hit ? DONE : CALC;
               else        state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      mcand             <= '0;
      mplr              <= '0;
      acc               <= '0;
      cnt               <= '0;
      neg               <= 1'b0;
      hi_half           <= 1'b0;
      fused             <= 1'b0;
      cache_valid       <= 1'b0;
      c_rs1             <= '0;
      c_rs2             <= '0;
      c_cls             <= '0;
      c_lvl             <= '0;
      cache_prod        <= '0;
      bus.mul_unit_busy <= 1'b0;
      bus.mul_valid     <= 1'b0;
      bus.mul_output    <= '0;
    end else begin
      bus.mul_unit_busy <= (state_n == CALC);

      if (accept) begin
        mcand   <= mag1;
        mplr    <= mag2;
        acc     <= '0;
        cnt     <= CW'(STEPS);
        neg     <= neg1 ^ neg2;
        hi_half <= (bus.funct3 != 3'b000);
        fused   <= cache_hit;
        c_rs1   <= bus.rs1;
        c_rs2   <= bus.rs2;
        c_cls   <= cls;
        c_lvl   <= lvl;
      end else if (state == CALC) begin
        acc  <= acc_sum >> STEP_BITS;
        mplr <= mplr >> STEP_BITS;
        cnt  <= cnt - CW'(1);
      end

      if (state == DONE) begin
        bus.mul_valid  <= 1'b1;
        bus.mul_output <= hi_half ? result[2*XLEN-1:XLEN] : result[XLEN-1:0];
        cache_prod     <= result;
      end else begin
        bus.mul_valid  <= 1'b0;
      end

      if (accept && !cache_hit) cache_valid <= 1'b0;
      else if (state == DONE)   cache_valid <= 1'b1;
    end
  end
endmodule
